dbg_tlm_axil_bridge: RTL and testbench
======================================

Name: dbg_tlm_axil_bridge

Overview:
- AXI4-Lite slave giving software and debugger access to the core's telemetry counters (mcycle, minstret, stall) and the instruction trace buffer.
- Sits downstream of the telemetry counters and trace RAM inside riscv_tcm_top, and drives the trace read address.
- Provides atomic 64-bit counter snapshots, sequenced trace readout that honours the RAM read latency, and control pulses for trace arm and counter clear.

Parameters:
- TRACE_DEPTH, 64, number of trace entries.
- TRACE_PTR_BITS, $clog2(TRACE_DEPTH), trace index width.
- TRACE_RD_LATENCY, 1, cycles from trace_rd_addr_o to valid trace data (1..3).
- ID_VALUE, 32'h5444_0001, value returned by the ID register.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- awvalid_i/awready_o  in/out  1  write address handshake.
- awaddr_i  in  8  write byte address.
- wvalid_i/wready_o  in/out  1  write data handshake.
- wdata_i  in  32  write data.
- wstrb_i  in  4  write byte strobes.
- bvalid_o/bready_i  out/in  1  write response handshake.
- bresp_o  out  2  write response code.
- arvalid_i/arready_o  in/out  1  read address handshake.
- araddr_i  in  8  read byte address.
- rvalid_o/rready_i  out/in  1  read response handshake.
- rdata_o  out  32  read data.
- rresp_o  out  2  read response code.
- tlm_mcycle_i, tlm_minstret_i, tlm_stall_i  in  64 each  live counters.
- trace_triggered_i  in  1  trace trigger status.
- trace_wr_ptr_i  in  TRACE_PTR_BITS  trace write pointer.
- trace_rd_addr_o  out  TRACE_PTR_BITS  trace RAM read address.
- trace_rd_pc_i, trace_rd_instr_i  in  32 each  trace RAM read data.
- trace_arm_o  out  1  one-cycle pulse that arms the trace trigger.
- tlm_clear_o  out  1  one-cycle pulse that clears the counters.

Behaviour:
- Register map (word-aligned; awaddr_i/araddr_i [1:0] ignored):
  - 0x00 ID (RO): ID_VALUE.
  - 0x04 CTRL (WO, reads 0): bit0 = pulse trace_arm_o; bit1 = pulse tlm_clear_o.
  - 0x08 STATUS (RO): bit0 = trace_triggered_i; bits[8+TRACE_PTR_BITS-1:8] = trace_wr_ptr_i; other bits 0.
  - 0x10 MCYCLE_LO (RO): reading it copies all three 64-bit inputs into the snapshot registers in the cycle the read is accepted, and returns the low word of the newly captured mcycle value.
  - 0x14 MCYCLE_HI, 0x18 MINSTRET_LO, 0x1C MINSTRET_HI, 0x20 STALL_LO, 0x24 STALL_HI (RO): return snapshot words; reading these never updates the snapshot.
  - 0x30 TRACE_IDX (RW): low TRACE_PTR_BITS bits are the index; upper bits write-ignored, read 0.
  - 0x34 TRACE_PC (RO): trace PC at TRACE_IDX.
  - 0x38 TRACE_INSTR (RO): trace instruction at TRACE_IDX; after the response, TRACE_IDX increments modulo TRACE_DEPTH.
  - Any other address: read returns 0 with SLVERR (2'b10); write is ignored with SLVERR.
- Writes take effect only when wstrb_i[0] is set. Register fields in this map live in byte 0 only, except TRACE_IDX, which uses wstrb_i[0] and, when TRACE_PTR_BITS > 8, wstrb_i[1]. A write with wstrb_i == 0 to a mapped address has no effect and returns OKAY.
- State machine: IDLE, RD_WAIT, RD_RESP, WR_RESP. One transaction outstanding at a time.
  - IDLE, write: when awvalid_i and wvalid_i are both high, assert awready_o and wready_o together for one cycle; apply the write; go to WR_RESP. Writes have priority over a simultaneous read.
  - IDLE, read: when arvalid_i is high and no write is accepted, assert arready_o for one cycle. Trace addresses go to RD_WAIT; all other addresses load rdata_o and go directly to RD_RESP.
  - RD_WAIT: stay exactly TRACE_RD_LATENCY cycles, capture trace_rd_pc_i or trace_rd_instr_i into rdata_o, then go to RD_RESP.
  - RD_RESP: hold rvalid_o high with rdata_o/rresp_o stable until rready_i; on the handshake go to IDLE and, for a TRACE_INSTR read, increment TRACE_IDX in the same cycle.
  - WR_RESP: hold bvalid_o high until bready_i; then go to IDLE.
- trace_rd_addr_o is a registered copy of TRACE_IDX and is stable throughout RD_WAIT.
- trace_arm_o and tlm_clear_o go high in the cycle after the write handshake for exactly one cycle.
- TRACE_IDX written to TRACE_DEPTH-1 followed by a TRACE_INSTR read wraps to 0.
- Reset (asynchronous, rst_i=1): all ready/valid outputs 0; rdata_o 0; bresp_o and rresp_o 0; pulse outputs 0; snapshots 0; TRACE_IDX 0; trace_rd_addr_o 0; state IDLE. Reset asserted mid-transaction abandons it immediately with no response issued.

Decomposition:
- Package dbg_tlm_pkg holds: register offset localparams; the AXI response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10; the state-machine state enum typedef; the ID_VALUE default.
- One sub-module: dbg_tlm_snapshot (three 64-bit capture registers with a capture enable).

Test Plan:
1. Release reset, read 0x00 -> rdata 0x5444_0001, rresp OKAY. Confirm every output held 0 during reset.
2. Drive mcycle=0x0000_0001_FFFF_FFF0 and read 0x10 -> 0xFFFF_FFF0. Change mcycle to 0x2_0000_0005, then read 0x14 -> 0x0000_0001 (snapshot held).
3. Write TRACE_IDX=62; read 0x34 -> model pc[62], with rvalid exactly TRACE_RD_LATENCY+1 cycles after the AR handshake. Read 0x38 -> instr[62], index becomes 63. Read 0x38 again -> instr[63], index wraps to 0.
4. Write CTRL=0x3 with wstrb=4'hF -> trace_arm_o and tlm_clear_o each high for exactly one cycle, bresp OKAY. Repeat with wstrb=0 -> no pulses, bresp OKAY.
5. Read 0x40 -> rdata 0, rresp SLVERR. Issue a simultaneous AW+W+AR -> the write completes first, then the read is serviced.
6. Assert rst_i during RD_WAIT -> rvalid_o stays 0, state returns to IDLE, TRACE_IDX=0; the next read of 0x00 succeeds.

Source files
------------

// File: rtl/dbg_tlm_pkg.sv
// rtl/dbg_tlm_pkg.sv - register map, response codes and FSM states for the telemetry debug bridge
package dbg_tlm_pkg;

   localparam logic [7:0] REG_ID          = 8'h00;
   localparam logic [7:0] REG_CTRL        = 8'h04;
   localparam logic [7:0] REG_STATUS      = 8'h08;
   localparam logic [7:0] REG_MCYCLE_LO   = 8'h10;
   localparam logic [7:0] REG_MCYCLE_HI   = 8'h14;
   localparam logic [7:0] REG_MINSTRET_LO = 8'h18;
   localparam logic [7:0] REG_MINSTRET_HI = 8'h1C;
   localparam logic [7:0] REG_STALL_LO    = 8'h20;
   localparam logic [7:0] REG_STALL_HI    = 8'h24;
   localparam logic [7:0] REG_TRACE_IDX   = 8'h30;
   localparam logic [7:0] REG_TRACE_PC    = 8'h34;
   localparam logic [7:0] REG_TRACE_INSTR = 8'h38;

   localparam logic [1:0]  RESP_OKAY        = 2'b00;
   localparam logic [1:0]  RESP_SLVERR      = 2'b10;
   localparam logic [31:0] ID_VALUE_DEFAULT = 32'h5444_0001;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_RD_RESP,
      ST_WR_RESP
   } state_e;

   function automatic logic reg_is_mapped(input logic [7:0] word_addr);
      case (word_addr)
         REG_ID, REG_CTRL, REG_STATUS, REG_MCYCLE_LO, REG_MCYCLE_HI,
         REG_MINSTRET_LO, REG_MINSTRET_HI, REG_STALL_LO, REG_STALL_HI,
         REG_TRACE_IDX, REG_TRACE_PC, REG_TRACE_INSTR: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dbg_tlm_axil_bridge_snapshot.sv
// rtl/dbg_tlm_axil_bridge_snapshot.sv - three 64-bit counter capture registers loaded together
module dbg_tlm_snapshot (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        capture_i,
   input  logic [63:0] mcycle_i,
   input  logic [63:0] minstret_i,
   input  logic [63:0] stall_i,
   output logic [63:0] mcycle_o,
   output logic [63:0] minstret_o,
   output logic [63:0] stall_o
);

   logic [63:0] mcycle_q, mcycle_d;
   logic [63:0] minstret_q, minstret_d;
   logic [63:0] stall_q, stall_d;

   always_comb begin
      mcycle_d   = mcycle_q;
      minstret_d = minstret_q;
      stall_d    = stall_q;
      if (capture_i) begin
         mcycle_d   = mcycle_i;
         minstret_d = minstret_i;
         stall_d    = stall_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
         stall_q    <= '0;
      end else begin
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
         stall_q    <= stall_d;
      end
   end

   assign mcycle_o   = mcycle_q;
   assign minstret_o = minstret_q;
   assign stall_o    = stall_q;

endmodule

// File: rtl/dbg_tlm_axil_bridge.sv
// rtl/dbg_tlm_axil_bridge.sv - AXI4-Lite slave exposing counter snapshots, trace readout and control pulses
module dbg_tlm_axil_bridge
   import dbg_tlm_pkg::*;
#(
   parameter int          TRACE_DEPTH      = 64,
   parameter int          TRACE_PTR_BITS   = $clog2(TRACE_DEPTH),
   parameter int          TRACE_RD_LATENCY = 1,
   parameter logic [31:0] ID_VALUE         = ID_VALUE_DEFAULT
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      awvalid_i,
   output logic                      awready_o,
   input  logic [7:0]                awaddr_i,
   input  logic                      wvalid_i,
   output logic                      wready_o,
   input  logic [31:0]               wdata_i,
   input  logic [3:0]                wstrb_i,
   output logic                      bvalid_o,
   input  logic                      bready_i,
   output logic [1:0]                bresp_o,
   input  logic                      arvalid_i,
   output logic                      arready_o,
   input  logic [7:0]                araddr_i,
   output logic                      rvalid_o,
   input  logic                      rready_i,
   output logic [31:0]               rdata_o,
   output logic [1:0]                rresp_o,
   input  logic [63:0]               tlm_mcycle_i,
   input  logic [63:0]               tlm_minstret_i,
   input  logic [63:0]               tlm_stall_i,
   input  logic                      trace_triggered_i,
   input  logic [TRACE_PTR_BITS-1:0] trace_wr_ptr_i,
   output logic [TRACE_PTR_BITS-1:0] trace_rd_addr_o,
   input  logic [31:0]               trace_rd_pc_i,
   input  logic [31:0]               trace_rd_instr_i,
   output logic                      trace_arm_o,
   output logic                      tlm_clear_o
);

   localparam logic [TRACE_PTR_BITS-1:0] IDX_LAST = TRACE_PTR_BITS'(TRACE_DEPTH - 1);

   state_e                    state_q, state_d;
   logic                      bvalid_q, bvalid_d;
   logic [1:0]                bresp_q, bresp_d;
   logic                      rvalid_q, rvalid_d;
   logic [1:0]                rresp_q, rresp_d;
   logic [31:0]               rdata_q, rdata_d;
   logic                      arm_q, arm_d;
   logic                      clear_q, clear_d;
   logic [TRACE_PTR_BITS-1:0] trace_idx_q, trace_idx_d;
   logic [TRACE_PTR_BITS-1:0] trace_rd_addr_q, trace_rd_addr_d;
   logic [1:0]                wait_q, wait_d;
   logic                      rd_instr_q, rd_instr_d;

   logic        wr_accept, rd_accept, snap_capture;
   logic [7:0]  wr_word, rd_word;
   logic [31:0] status_w, idx_wr;
   logic [63:0] snap_mcycle, snap_minstret, snap_stall;
   logic        unused_bits;

   assign wr_word = {awaddr_i[7:2], 2'b00};
   assign rd_word = {araddr_i[7:2], 2'b00};
   assign unused_bits = ^{awaddr_i[1:0], araddr_i[1:0], wdata_i[31:16], wstrb_i[3:2],
                          snap_mcycle[31:0]};

   always_comb begin
      status_w                      = '0;
      status_w[0]                   = trace_triggered_i;
      status_w[8 +: TRACE_PTR_BITS] = trace_wr_ptr_i;
   end

   dbg_tlm_snapshot u_snapshot (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .capture_i  (snap_capture),
      .mcycle_i   (tlm_mcycle_i),
      .minstret_i (tlm_minstret_i),
      .stall_i    (tlm_stall_i),
      .mcycle_o   (snap_mcycle),
      .minstret_o (snap_minstret),
      .stall_o    (snap_stall)
   );

   always_comb begin
      state_d      = state_q;
      bvalid_d     = bvalid_q;
      bresp_d      = bresp_q;
      rvalid_d     = rvalid_q;
      rresp_d      = rresp_q;
      rdata_d      = rdata_q;
      arm_d        = 1'b0;
      clear_d      = 1'b0;
      trace_idx_d  = trace_idx_q;
      wait_d       = wait_q;
      rd_instr_d   = rd_instr_q;
      wr_accept    = 1'b0;
      rd_accept    = 1'b0;
      snap_capture = 1'b0;
      idx_wr       = '0;

      case (state_q)
         ST_IDLE: begin
            // Readies are gated by reset so nothing is accepted while it is held.
            if (!rst_i && awvalid_i && wvalid_i) begin
               wr_accept = 1'b1;
               state_d   = ST_WR_RESP;
               bvalid_d  = 1'b1;
               bresp_d   = reg_is_mapped(wr_word) ? RESP_OKAY : RESP_SLVERR;
               if (wstrb_i[0]) begin
                  case (wr_word)
                     REG_CTRL: begin
                        arm_d   = wdata_i[0];
                        clear_d = wdata_i[1];
                     end
                     REG_TRACE_IDX: begin
                        idx_wr       = 32'(trace_idx_q);
                        idx_wr[7:0]  = wdata_i[7:0];
                        if (wstrb_i[1]) idx_wr[15:8] = wdata_i[15:8];
                        trace_idx_d  = idx_wr[TRACE_PTR_BITS-1:0];
                     end
                     default: ;
                  endcase
               end
            end else if (!rst_i && arvalid_i) begin
               rd_accept  = 1'b1;
               rresp_d    = RESP_OKAY;
               rdata_d    = '0;
               rd_instr_d = 1'b0;
               state_d    = ST_RD_RESP;
               rvalid_d   = 1'b1;
               case (rd_word)
                  REG_ID:          rdata_d = ID_VALUE;
                  REG_CTRL:        rdata_d = '0;
                  REG_STATUS:      rdata_d = status_w;
                  REG_MCYCLE_LO: begin
                     snap_capture = 1'b1;
                     rdata_d      = tlm_mcycle_i[31:0];
                  end
                  REG_MCYCLE_HI:   rdata_d = snap_mcycle[63:32];
                  REG_MINSTRET_LO: rdata_d = snap_minstret[31:0];
                  REG_MINSTRET_HI: rdata_d = snap_minstret[63:32];
                  REG_STALL_LO:    rdata_d = snap_stall[31:0];
                  REG_STALL_HI:    rdata_d = snap_stall[63:32];
                  REG_TRACE_IDX:   rdata_d = 32'(trace_idx_q);
                  REG_TRACE_PC, REG_TRACE_INSTR: begin
                     state_d    = ST_RD_WAIT;
                     rvalid_d   = 1'b0;
                     wait_d     = 2'(TRACE_RD_LATENCY - 1);
                     rd_instr_d = (rd_word == REG_TRACE_INSTR);
                  end
                  default:         rresp_d = RESP_SLVERR;
               endcase
            end
         end
         ST_RD_WAIT: begin
            if (wait_q == 2'd0) begin
               rdata_d  = rd_instr_q ? trace_rd_instr_i : trace_rd_pc_i;
               rvalid_d = 1'b1;
               state_d  = ST_RD_RESP;
            end else begin
               wait_d = wait_q - 2'd1;
            end
         end
         ST_RD_RESP: begin
            if (rready_i) begin
               rvalid_d = 1'b0;
               state_d  = ST_IDLE;
               if (rd_instr_q)
                  trace_idx_d = (trace_idx_q == IDX_LAST) ? '0 : trace_idx_q + TRACE_PTR_BITS'(1);
            end
         end
         ST_WR_RESP: begin
            if (bready_i) begin
               bvalid_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Tracking the next index keeps the RAM address settled before any trace read is accepted.
      trace_rd_addr_d = trace_idx_d;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q         <= ST_IDLE;
         bvalid_q        <= 1'b0;
         bresp_q         <= RESP_OKAY;
         rvalid_q        <= 1'b0;
         rresp_q         <= RESP_OKAY;
         rdata_q         <= '0;
         arm_q           <= 1'b0;
         clear_q         <= 1'b0;
         trace_idx_q     <= '0;
         trace_rd_addr_q <= '0;
         wait_q          <= '0;
         rd_instr_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         bvalid_q        <= bvalid_d;
         bresp_q         <= bresp_d;
         rvalid_q        <= rvalid_d;
         rresp_q         <= rresp_d;
         rdata_q         <= rdata_d;
         arm_q           <= arm_d;
         clear_q         <= clear_d;
         trace_idx_q     <= trace_idx_d;
         trace_rd_addr_q <= trace_rd_addr_d;
         wait_q          <= wait_d;
         rd_instr_q      <= rd_instr_d;
      end
   end

   assign awready_o       = wr_accept;
   assign wready_o        = wr_accept;
   assign arready_o       = rd_accept;
   assign bvalid_o        = bvalid_q;
   assign bresp_o         = bresp_q;
   assign rvalid_o        = rvalid_q;
   assign rresp_o         = rresp_q;
   assign rdata_o         = rdata_q;
   assign trace_arm_o     = arm_q;
   assign tlm_clear_o     = clear_q;
   assign trace_rd_addr_o = trace_rd_addr_q;

endmodule

// File: tb/tb_dbg_tlm_axil_bridge.sv
// tb/tb_dbg_tlm_axil_bridge.sv - directed self-checking bench for dbg_tlm_axil_bridge
module tb_dbg_tlm_axil_bridge;

   localparam int PB = 6;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          awvalid_i, awready_o, wvalid_i, wready_o;
   logic [7:0]    awaddr_i, araddr_i;
   logic [31:0]   wdata_i;
   logic [3:0]    wstrb_i;
   logic          bvalid_o, bready_i, arvalid_i, arready_o, rvalid_o, rready_i;
   logic [1:0]    bresp_o, rresp_o;
   logic [31:0]   rdata_o;
   logic [63:0]   tlm_mcycle_i, tlm_minstret_i, tlm_stall_i;
   logic          trace_triggered_i;
   logic [PB-1:0] trace_wr_ptr_i, trace_rd_addr_o;
   logic [31:0]   trace_rd_pc_i, trace_rd_instr_i;
   logic          trace_arm_o, tlm_clear_o;

   int errors = 0;
   int checks = 0;
   int arm_cnt = 0;
   int clr_cnt = 0;

   dbg_tlm_axil_bridge dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .awvalid_i(awvalid_i), .awready_o(awready_o), .awaddr_i(awaddr_i),
      .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
      .bvalid_o(bvalid_o), .bready_i(bready_i), .bresp_o(bresp_o),
      .arvalid_i(arvalid_i), .arready_o(arready_o), .araddr_i(araddr_i),
      .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rresp_o(rresp_o),
      .tlm_mcycle_i(tlm_mcycle_i), .tlm_minstret_i(tlm_minstret_i), .tlm_stall_i(tlm_stall_i),
      .trace_triggered_i(trace_triggered_i), .trace_wr_ptr_i(trace_wr_ptr_i),
      .trace_rd_addr_o(trace_rd_addr_o), .trace_rd_pc_i(trace_rd_pc_i),
      .trace_rd_instr_i(trace_rd_instr_i), .trace_arm_o(trace_arm_o), .tlm_clear_o(tlm_clear_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] pc_of(input int i);
      return 32'h8000_0000 + 32'(i * 4);
   endfunction

   function automatic logic [31:0] instr_of(input int i);
      return 32'h0000_0013 | (32'(i) << 7);
   endfunction

   // One-cycle-latency trace RAM
   always @(posedge clk_i) begin
      trace_rd_pc_i    <= pc_of(int'(trace_rd_addr_o));
      trace_rd_instr_i <= instr_of(int'(trace_rd_addr_o));
   end

   always @(posedge clk_i) begin
      if (trace_arm_o) arm_cnt++;
      if (tlm_clear_o) clr_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
      int n = 0;
      araddr_i  = addr;
      arvalid_i = 1'b1;
      #1;
      while (!arready_o && n < 20) begin
         @(negedge clk_i); #1; n++;
      end
      chk("arready", arready_o, 1);
      @(negedge clk_i);
      arvalid_i = 1'b0;
      lat = 1;
      while (!rvalid_o && lat < 20) begin
         @(negedge clk_i); lat++;
      end
      chk("rvalid", rvalid_o, 1);
      data = rdata_o;
      resp = rresp_o;
      @(negedge clk_i);
      chk("rhold", {rvalid_o, rdata_o, rresp_o}, {1'b1, data, resp});
      rready_i = 1'b1;
      @(negedge clk_i);
      rready_i = 1'b0;
   endtask

   task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      int n = 0;
      awaddr_i  = addr;
      wdata_i   = data;
      wstrb_i   = strb;
      awvalid_i = 1'b1;
      wvalid_i  = 1'b1;
      #1;
      while (!(awready_o && wready_o) && n < 20) begin
         @(negedge clk_i); #1; n++;
      end
      chk("awready_wready", {awready_o, wready_o}, 2'b11);
      @(negedge clk_i);
      awvalid_i = 1'b0;
      wvalid_i  = 1'b0;
      n = 0;
      while (!bvalid_o && n < 20) begin
         @(negedge clk_i); n++;
      end
      chk("bvalid", bvalid_o, 1);
      resp     = bresp_o;
      bready_i = 1'b1;
      @(negedge clk_i);
      bready_i = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      int          a0, c0;

      rst_i = 1'b1;
      awvalid_i = 1'b1; wvalid_i = 1'b1; arvalid_i = 1'b1;
      awaddr_i = 8'h04; wdata_i = 32'h3; wstrb_i = 4'hF; araddr_i = 8'h00;
      bready_i = 1'b0; rready_i = 1'b0;
      tlm_mcycle_i = '0; tlm_minstret_i = '0; tlm_stall_i = '0;
      trace_triggered_i = 1'b0; trace_wr_ptr_i = '0;

      // 1: outputs quiet under reset even with requests pending
      repeat (3) @(negedge clk_i);
      chk("reset_outputs",
          {awready_o, wready_o, arready_o, bvalid_o, rvalid_o, bresp_o, rresp_o,
           rdata_o, trace_arm_o, tlm_clear_o, trace_rd_addr_o},
          '0);
      awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0;
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("reset_no_pulses", arm_cnt + clr_cnt, 0);
      axi_read(8'h00, d, r, lat);
      chk("id_data", d, 32'h5444_0001);
      chk("id_resp", r, 2'b00);
      chk("id_lat", lat, 1);

      trace_triggered_i = 1'b1; trace_wr_ptr_i = 6'd37;
      axi_read(8'h08, d, r, lat);
      chk("status", d, 32'h0000_2501);

      // 2: snapshot
      tlm_mcycle_i   = 64'h0000_0001_FFFF_FFF0;
      tlm_minstret_i = 64'h0000_00AB_0000_1234;
      tlm_stall_i    = 64'h0000_0007_0000_0009;
      axi_read(8'h10, d, r, lat);
      chk("mcycle_lo", d, 32'hFFFF_FFF0);
      tlm_mcycle_i   = 64'h0000_0002_0000_0005;
      tlm_minstret_i = 64'hFFFF_FFFF_FFFF_FFFF;
      tlm_stall_i    = 64'hFFFF_FFFF_FFFF_FFFF;
      axi_read(8'h14, d, r, lat);
      chk("mcycle_hi_held", d, 32'h0000_0001);
      axi_read(8'h18, d, r, lat);
      chk("minstret_lo", d, 32'h0000_1234);
      axi_read(8'h1C, d, r, lat);
      chk("minstret_hi", d, 32'h0000_00AB);
      axi_read(8'h24, d, r, lat);
      chk("stall_hi", d, 32'h0000_0007);

      // 3: trace readout, upper index bits ignored, wrap at depth
      axi_write(8'h30, 32'hABCD_00FE, 4'hF, r);
      chk("idx_wr_resp", r, 2'b00);
      axi_read(8'h30, d, r, lat);
      chk("idx_62", d, 32'd62);
      chk("rd_addr_62", trace_rd_addr_o, 6'd62);
      axi_read(8'h34, d, r, lat);
      chk("pc_62", d, pc_of(62));
      chk("pc_lat", lat, 2);
      axi_read(8'h38, d, r, lat);
      chk("instr_62", d, instr_of(62));
      chk("instr_lat", lat, 2);
      axi_read(8'h30, d, r, lat);
      chk("idx_63", d, 32'd63);
      axi_read(8'h38, d, r, lat);
      chk("instr_63", d, instr_of(63));
      axi_read(8'h30, d, r, lat);
      chk("idx_wrap", d, 32'd0);

      // 4: control pulses
      a0 = arm_cnt; c0 = clr_cnt;
      axi_write(8'h04, 32'h3, 4'hF, r);
      repeat (3) @(negedge clk_i);
      chk("ctrl_resp", r, 2'b00);
      chk("arm_pulse", arm_cnt - a0, 1);
      chk("clr_pulse", clr_cnt - c0, 1);
      a0 = arm_cnt; c0 = clr_cnt;
      axi_write(8'h04, 32'h3, 4'h0, r);
      repeat (3) @(negedge clk_i);
      chk("ctrl_nostrb_resp", r, 2'b00);
      chk("nostrb_pulses", (arm_cnt - a0) + (clr_cnt - c0), 0);
      axi_read(8'h04, d, r, lat);
      chk("ctrl_reads_0", d, 32'd0);

      // 5: unmapped and write-over-read priority
      axi_read(8'h40, d, r, lat);
      chk("bad_rd_data", d, 32'd0);
      chk("bad_rd_resp", r, 2'b10);
      axi_write(8'h44, 32'h1, 4'hF, r);
      chk("bad_wr_resp", r, 2'b10);
      awaddr_i = 8'h30; wdata_i = 32'd5; wstrb_i = 4'h1;
      awvalid_i = 1'b1; wvalid_i = 1'b1; araddr_i = 8'h30; arvalid_i = 1'b1;
      #1;
      chk("prio_ready", {awready_o, wready_o, arready_o}, 3'b110);
      @(negedge clk_i);
      awvalid_i = 1'b0; wvalid_i = 1'b0;
      #1;
      chk("prio_bvalid_no_ar", {bvalid_o, arready_o}, 2'b10);
      bready_i = 1'b1;
      @(negedge clk_i);
      bready_i = 1'b0;
      axi_read(8'h30, d, r, lat);
      chk("prio_read_after_write", d, 32'd5);

      // 6: reset during trace wait
      axi_write(8'h30, 32'd10, 4'h1, r);
      araddr_i = 8'h34; arvalid_i = 1'b1;
      #1;
      chk("rst_ar", arready_o, 1);
      @(negedge clk_i);
      arvalid_i = 1'b0;
      rst_i = 1'b1;
      #1;
      chk("rst_mid_outs", {rvalid_o, trace_rd_addr_o}, '0);
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("rst_no_rvalid", rvalid_o, 0);
      axi_read(8'h30, d, r, lat);
      chk("rst_idx", d, 32'd0);
      axi_read(8'h00, d, r, lat);
      chk("rst_id", {r, d}, {2'b00, 32'h5444_0001});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
